vga_plot_queue: RTL and testbench

VGA_PLOT_QUEUE -- requirements
Module: vga_plot_queue

---
 rtl/flow_vga_pkg.sv | 19 +
 rtl/plot_fifo.sv | 45 ++++
 rtl/vga_plot_queue.sv | 151 +++++++++++++++
 tb/tb_vga_plot_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_vga_pkg.sv
// Shared VGA plotting constants and the packed pixel type used by the plot queue.
package flow_vga_pkg;
  localparam int VGA_X_MAX   = 159;
  localparam int VGA_Y_MAX   = 119;
  localparam int VGA_COLOR_W = 15;
  localparam int VGA_X_W     = 8;
  localparam int VGA_Y_W     = 7;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] color;
    logic [VGA_X_W-1:0]     x;
    logic [VGA_Y_W-1:0]     y;
  } pixel_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } plot_state_e;
endpackage

// File: rtl/plot_fifo.sv
// Pixel FIFO: storage array plus read/write pointers and occupancy count.
// The caller only pushes when not full and only pops when not empty.
module plot_fifo
  import flow_vga_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  pixel_t                 wr_data,
  output pixel_t                 rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; only valid entries are ever read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/vga_plot_queue.sv
// Buffers plot requests ahead of the VGA adapter and optionally sweeps a full-screen clear.
// The clear engine is compiled in only when FLOW_VGA_CLEAR_EN is defined.
module vga_plot_queue
  import flow_vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int X_MAX = VGA_X_MAX,
  parameter int Y_MAX = VGA_Y_MAX
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [VGA_COLOR_W-1:0] in_color,
  input  logic [VGA_X_W-1:0]     in_x,
  input  logic [VGA_Y_W-1:0]     in_y,
  input  logic                   in_plot,
  input  logic                   clear_req,
  input  logic [VGA_COLOR_W-1:0] clear_color,
  output logic [VGA_COLOR_W-1:0] out_color,
  output logic [VGA_X_W-1:0]     out_x,
  output logic [VGA_Y_W-1:0]     out_y,
  output logic                   out_plot,
  output logic                   full,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);
  localparam logic [VGA_X_W-1:0] X_LAST = VGA_X_W'(X_MAX);
  localparam logic [VGA_Y_W-1:0] Y_LAST = VGA_Y_W'(Y_MAX);

  pixel_t in_pix;
  pixel_t rd_data;
  pixel_t sweep_pix;
  pixel_t out_q;
  logic   in_range;
  logic   push_ok;
  logic   pop;
  logic   empty;
  logic   sweep_vld;
  logic   sweep_active;

  assign in_pix   = {in_color, in_x, in_y};
  assign in_range = (in_x <= X_LAST) && (in_y <= Y_LAST);
  // full is the pre-pop value, so a full FIFO refuses a push even on a pop cycle.
  assign push_ok  = in_plot && in_range && !full;

  plot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push_ok),
    .pop     (pop),
    .wr_data (in_pix),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

`ifdef FLOW_VGA_CLEAR_EN
  plot_state_e            state_q;
  plot_state_e            state_d;
  logic [VGA_X_W-1:0]     sweep_x;
  logic [VGA_Y_W-1:0]     sweep_y;
  logic [VGA_COLOR_W-1:0] sweep_color;
  logic                   clear_go;
  logic                   sweep_last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // A clear request beats a pending pop on the same cycle.
  always_comb begin
    state_d    = state_q;
    clear_go   = 1'b0;
    pop        = 1'b0;
    sweep_vld  = 1'b0;
    sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
    case (state_q)
      ST_RUN: begin
        if (clear_req) begin
          state_d  = ST_CLEAR;
          clear_go = 1'b1;
        end else begin
          pop = !empty;
        end
      end
      ST_CLEAR: begin
        sweep_vld = 1'b1;
        if (sweep_last) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sweep_x     <= '0;
      sweep_y     <= '0;
      sweep_color <= '0;
    end else if (clear_go) begin
      sweep_x     <= '0;
      sweep_y     <= '0;
      sweep_color <= clear_color;
    end else if (state_q == ST_CLEAR) begin
      if (sweep_x == X_LAST) begin
        sweep_x <= '0;
        sweep_y <= sweep_y + 1'b1;
      end else begin
        sweep_x <= sweep_x + 1'b1;
      end
    end
  end

  assign sweep_pix    = {sweep_color, sweep_x, sweep_y};
  assign sweep_active = (state_q == ST_CLEAR);
`else
  logic unused_clear;

  assign unused_clear = ^{clear_req, clear_color};
  assign pop          = !empty;
  assign sweep_vld    = 1'b0;
  assign sweep_pix    = '0;
  assign sweep_active = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) overflow <= 1'b0;
    else if (in_plot && in_range && full) overflow <= 1'b1;
  end

  // Output stage: registered pixel and strobe towards the adapter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      out_plot <= 1'b0;
    end else if (pop) begin
      out_q    <= rd_data;
      out_plot <= 1'b1;
    end else if (sweep_vld) begin
      out_q    <= sweep_pix;
      out_plot <= 1'b1;
    end else begin
      out_plot <= 1'b0;
    end
  end

  assign out_color = out_q.color;
  assign out_x     = out_q.x;
  assign out_y     = out_q.y;
  assign busy      = sweep_active || (count != '0);
endmodule

// File: tb/tb_vga_plot_queue.sv
// Scoreboard bench for vga_plot_queue: stimulus queues expected pixels, a monitor checks every out_plot.
module tb_vga_plot_queue;
  import flow_vga_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] in_color = '0;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic        in_plot = 1'b0;
  logic        clear_req = 1'b0;
  logic [14:0] clear_color = '0;
  logic [14:0] out_color;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic        out_plot;
  logic        full;
  logic        busy;
  logic        overflow;
  logic [4:0]  count;

  vga_plot_queue #(.DEPTH(16), .X_MAX(159), .Y_MAX(119)) dut (
    .clock(clock), .resetn(resetn),
    .in_color(in_color), .in_x(in_x), .in_y(in_y), .in_plot(in_plot),
    .clear_req(clear_req), .clear_color(clear_color),
    .out_color(out_color), .out_x(out_x), .out_y(out_y), .out_plot(out_plot),
    .full(full), .busy(busy), .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];
  int n_out = 0;
  int run_len = 0;
  int last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every issued pixel must match the head of the expected queue.
  always @(negedge clock) begin
    if (resetn && out_plot) begin
      n_out++;
      run_len++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0h, expected no pixel", {out_color, out_x, out_y});
      end else begin
        chk("pixel", {2'b0, out_color, out_x, out_y}, {2'b0, exp_q.pop_front()});
      end
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [29:0] pix(input int c, input int x, input int y);
    logic [14:0] cc;
    logic [7:0]  xx;
    logic [6:0]  yy;
    cc = c[14:0];
    xx = x[7:0];
    yy = y[6:0];
    return {cc, xx, yy};
  endfunction

  // Expected raster of a full-screen clear, computed directly from the screen size.
  task automatic expect_sweep(input int c);
    for (int y = 0; y <= VGA_Y_MAX; y++)
      for (int x = 0; x <= VGA_X_MAX; x++)
        exp_q.push_back(pix(c, x, y));
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((busy || out_plot || exp_q.size() != 0) && g < 25000) begin
      tick();
      g++;
    end
    tick();
    chk(name, {31'b0, (g < 25000)}, 32'd1);
  endtask

  task automatic wait_out(input int target, input string name);
    int g = 0;
    while (n_out < target && g < 25000) begin
      tick();
      g++;
    end
    chk(name, {31'b0, (n_out >= target)}, 32'd1);
  endtask

  initial begin
    int x, y, c, base;
    bit go;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_out_plot", {31'b0, out_plot}, 32'd0);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_xy", {17'b0, out_x, out_y}, 32'd0);
    chk("rst_color", {17'b0, out_color}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Single push: strobe two cycles later, for one cycle.
    in_plot = 1'b1; in_x = 8'd5; in_y = 7'd7; in_color = 15'h7FFF;
    exp_q.push_back(pix(15'h7FFF, 5, 7));
    tick();
    in_plot = 1'b0;
    @(negedge clock);
    chk("lat_early_plot", {31'b0, out_plot}, 32'd0);
    tick();
    @(negedge clock);
    chk("lat_plot", {31'b0, out_plot}, 32'd1);
    chk("lat_xy", {17'b0, out_x, out_y}, {17'b0, 8'd5, 7'd7});
    chk("lat_color", {17'b0, out_color}, {17'b0, 15'h7FFF});
    chk("lat_busy", {31'b0, busy}, 32'd0);
    tick();
    @(negedge clock);
    chk("lat_single_pulse", {31'b0, out_plot}, 32'd0);
    tick();

    // Out-of-range coordinates are dropped silently.
    in_plot = 1'b1; in_x = 8'd160; in_y = 7'd0; in_color = 15'h1234;
    tick();
    in_x = 8'd0; in_y = 7'd120;
    tick();
    in_plot = 1'b0;
    @(negedge clock);
    chk("oor_count", {27'b0, count}, 32'd0);
    repeat (4) tick();
    chk("oor_overflow", {31'b0, overflow}, 32'd0);
    chk("oor_no_output", n_out, 32'd1);

    // Random plot traffic, some of it out of range.
    for (int i = 0; i < 400; i++) begin
      go = ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, 175);
      y = $urandom_range(0, 127);
      c = $urandom_range(0, 32767);
      in_plot = go; in_x = x[7:0]; in_y = y[6:0]; in_color = c[14:0];
`ifndef FLOW_VGA_CLEAR_EN
      clear_req = ($urandom_range(0, 9) == 0);
      clear_color = 15'h001F;
`endif
      if (go && x <= VGA_X_MAX && y <= VGA_Y_MAX) exp_q.push_back(pix(c, x, y));
      tick();
    end
    in_plot = 1'b0;
    clear_req = 1'b0;
    wait_idle("rand_drain");
    chk("rand_overflow", {31'b0, overflow}, 32'd0);
    chk("rand_busy", {31'b0, busy}, 32'd0);

`ifdef FLOW_VGA_CLEAR_EN
    // Clear with a repeated request mid-sweep, and pushes that overfill the FIFO.
    base = n_out;
    clear_req = 1'b1; clear_color = 15'h001F;
    expect_sweep(15'h001F);
    tick();
    clear_req = 1'b0;
    clear_color = 15'h7C00;
    wait_out(base + 100, "clear_reach_100");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 17; i++) begin
      x = $urandom_range(0, VGA_X_MAX);
      y = $urandom_range(0, VGA_Y_MAX);
      c = $urandom_range(0, 32767);
      in_plot = 1'b1; in_x = x[7:0]; in_y = y[6:0]; in_color = c[14:0];
      if (i < 16) exp_q.push_back(pix(c, x, y));
      tick();
    end
    in_plot = 1'b0;
    @(negedge clock);
    chk("fill_count", {27'b0, count}, 32'd16);
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_overflow", {31'b0, overflow}, 32'd1);
    chk("fill_busy", {31'b0, busy}, 32'd1);
    wait_idle("clear_drain");
    chk("clear_run_len", last_run, 32'd19216);
    chk("clear_total", n_out - base, 32'd19216);

    // Clear wins over a pending pop, then reset aborts the sweep.
    tick();
    in_plot = 1'b1; in_x = 8'd9; in_y = 7'd3; in_color = 15'h0ABC;
    tick();
    in_plot = 1'b0;
    clear_req = 1'b1; clear_color = 15'h03E0;
    expect_sweep(15'h03E0);
    exp_q.push_back(pix(15'h0ABC, 9, 3));
    base = n_out;
    tick();
    clear_req = 1'b0;
    @(negedge clock);
    chk("clear_wins_count", {27'b0, count}, 32'd1);
    chk("clear_wins_busy", {31'b0, busy}, 32'd1);
    wait_out(base + 5000, "clear_reach_5000");
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_plot_now", {31'b0, out_plot}, 32'd0);
    @(negedge clock);
    chk("abort_plot_edge", {31'b0, out_plot}, 32'd0);
    tick();
    resetn = 1'b1;
    base = n_out;
    repeat (40) tick();
    chk("abort_no_output", n_out - base, 32'd0);
    chk("abort_count", {27'b0, count}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_overflow", {31'b0, overflow}, 32'd0);
    in_plot = 1'b1; in_x = 8'd159; in_y = 7'd119; in_color = 15'h5555;
    exp_q.push_back(pix(15'h5555, 159, 119));
    tick();
    in_plot = 1'b0;
    wait_idle("post_abort_drain");
`else
    // Clear requests are inert in this build.
    base = n_out;
    clear_req = 1'b1; clear_color = 15'h001F;
    tick();
    clear_req = 1'b0;
    repeat (20) tick();
    chk("noclear_output", n_out - base, 32'd0);
    chk("noclear_busy", {31'b0, busy}, 32'd0);
`endif

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
